// File: rtl/cmd_frame_master.sv
// Host-side command framer: serialises a latched command into UART bytes,
// then collects the 0/1/2-byte response or times out waiting for it.
module cmd_frame_master #(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic [1:0]  CMD_TYPE,
  input  logic [7:0]  CMD_ADDR,
  input  logic [7:0]  CMD_WDATA,
  input  logic [7:0]  CMD_OP_A,
  input  logic [7:0]  CMD_OP_B,
  input  logic [3:0]  CMD_FUNC,
  output logic [7:0]  TX_DATA,
  output logic        TX_VALID,
  input  logic        TX_BUSY,
  input  logic [7:0]  RX_DATA,
  input  logic        RX_DATA_VALID,
  output logic [15:0] RSP_DATA,
  output logic        CMD_DONE,
  output logic        RSP_TIMEOUT
);
  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, SEND, WAIT_RSP, DONE} state_t;

  state_t          state, state_next;
  logic [1:0]      type_q;
  logic [7:0]      addr_q, wdata_q, opa_q, opb_q;
  logic [3:0]      func_q;
  logic [1:0]      idx;
  logic [CW-1:0]   tmo_cnt;
  logic            rx_got;
  logic [7:0]      rx_lo;
  logic [7:0]      next_byte;
  logic            tx_acc, last_tx, rx_last, tmo_hit;

  function automatic logic [7:0] header(input logic [1:0] t);
    case (t)
      2'b00:   return 8'hAA;
      2'b01:   return 8'hBB;
      2'b10:   return 8'hCC;
      default: return 8'hDD;
    endcase
  endfunction

  function automatic logic [1:0] last_idx(input logic [1:0] t);
    case (t)
      2'b00:   return 2'd2;
      2'b10:   return 2'd3;
      default: return 2'd1;
    endcase
  endfunction

  assign CMD_READY = (state == IDLE);
  assign CMD_DONE  = (state == DONE);

  // Byte following the one currently offered (idx), taken from latched fields
  always_comb begin
    next_byte = '0;
    case (type_q)
      2'b00:   next_byte = (idx == 2'd0) ? addr_q : wdata_q;
      2'b01:   next_byte = addr_q;
      2'b10: begin
        case (idx)
          2'd0:    next_byte = opa_q;
          2'd1:    next_byte = opb_q;
          default: next_byte = {4'h0, func_q};
        endcase
      end
      default: next_byte = {4'h0, func_q};
    endcase
  end

  always_comb begin
    state_next = state;
    tx_acc     = TX_VALID && !TX_BUSY;
    last_tx    = (idx == last_idx(type_q));
    rx_last    = (type_q == 2'b01) || rx_got;
    tmo_hit    = (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
    case (state)
      IDLE:     if (CMD_VALID) state_next = SEND;
      SEND:     if (tx_acc && last_tx) state_next = (type_q == 2'b00) ? DONE : WAIT_RSP;
      WAIT_RSP: if ((RX_DATA_VALID && rx_last) || (!RX_DATA_VALID && tmo_hit)) state_next = DONE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_next;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      type_q      <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      func_q      <= '0;
      idx         <= '0;
      tmo_cnt     <= '0;
      rx_got      <= 1'b0;
      rx_lo       <= '0;
      TX_VALID    <= 1'b0;
      TX_DATA     <= '0;
      RSP_DATA    <= '0;
      RSP_TIMEOUT <= 1'b0;
    end else begin
      case (state)
        IDLE: if (CMD_VALID) begin
          type_q   <= CMD_TYPE;
          addr_q   <= CMD_ADDR;
          wdata_q  <= CMD_WDATA;
          opa_q    <= CMD_OP_A;
          opb_q    <= CMD_OP_B;
          func_q   <= CMD_FUNC;
          idx      <= '0;
          TX_VALID <= 1'b1;
          TX_DATA  <= header(CMD_TYPE);
        end
        SEND: if (tx_acc) begin
          if (last_tx) begin
            TX_VALID <= 1'b0;
            tmo_cnt  <= '0;
            rx_got   <= 1'b0;
            if (type_q == 2'b00) begin
              RSP_DATA    <= '0;
              RSP_TIMEOUT <= 1'b0;
            end
          end else begin
            idx     <= idx + 2'd1;
            TX_DATA <= next_byte;
          end
        end
        WAIT_RSP: begin
          if (RX_DATA_VALID) begin
            tmo_cnt <= '0;
            rx_got  <= 1'b1;
            rx_lo   <= RX_DATA;
            if (rx_last) begin
              RSP_DATA    <= (type_q == 2'b01) ? {8'h00, RX_DATA} : {RX_DATA, rx_lo};
              RSP_TIMEOUT <= 1'b0;
            end
          end else if (tmo_hit) begin
            RSP_DATA    <= '0;
            RSP_TIMEOUT <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cmd_frame_master.sv
// Directed bench for cmd_frame_master: a transaction-level model (byte queues,
// silence counter) is compared every cycle, plus literal per-scenario checks.
module tb_cmd_frame_master;
  localparam int unsigned TMO = 16;

  logic        CLK = 1'b0;
  logic        RST;
  logic        CMD_VALID, CMD_READY;
  logic [1:0]  CMD_TYPE;
  logic [7:0]  CMD_ADDR, CMD_WDATA, CMD_OP_A, CMD_OP_B;
  logic [3:0]  CMD_FUNC;
  logic [7:0]  TX_DATA;
  logic        TX_VALID, TX_BUSY;
  logic [7:0]  RX_DATA;
  logic        RX_DATA_VALID;
  logic [15:0] RSP_DATA;
  logic        CMD_DONE, RSP_TIMEOUT;

  cmd_frame_master #(.TIMEOUT_CYCLES(TMO)) dut (
    .CLK(CLK), .RST(RST),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_TYPE(CMD_TYPE),
    .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA), .CMD_OP_A(CMD_OP_A),
    .CMD_OP_B(CMD_OP_B), .CMD_FUNC(CMD_FUNC),
    .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_BUSY(TX_BUSY),
    .RX_DATA(RX_DATA), .RX_DATA_VALID(RX_DATA_VALID),
    .RSP_DATA(RSP_DATA), .CMD_DONE(CMD_DONE), .RSP_TIMEOUT(RSP_TIMEOUT)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;
  int cyc_n = 0;
  bit checking = 0;

  always @(posedge CLK) cyc_n <= cyc_n + 1;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  // Model: frame bytes still to go, response bytes gathered, silent cycles seen
  logic [7:0]  m_txq[$];
  logic [7:0]  m_rx[$];
  int          m_need, m_idle;
  bit          m_wait, m_done;
  logic [15:0] m_rsp;
  logic        m_tmo;

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      m_txq.delete(); m_rx.delete();
      m_need = 0; m_idle = 0; m_wait = 0; m_done = 0;
      m_rsp = '0; m_tmo = 1'b0;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_txq.size() != 0) begin
      if (!TX_BUSY) begin
        void'(m_txq.pop_front());
        if (m_txq.size() == 0) begin
          if (m_need == 0) begin
            m_done = 1; m_rsp = '0; m_tmo = 1'b0;
          end else begin
            m_wait = 1; m_idle = 0; m_rx.delete();
          end
        end
      end
    end else if (m_wait) begin
      if (RX_DATA_VALID) begin
        m_rx.push_back(RX_DATA);
        m_idle = 0;
        if (m_rx.size() == m_need) begin
          m_wait = 0; m_done = 1; m_tmo = 1'b0;
          m_rsp = (m_need == 1) ? {8'h00, m_rx[0]} : {m_rx[1], m_rx[0]};
        end
      end else begin
        m_idle++;
        if (m_idle == TMO) begin
          m_wait = 0; m_done = 1; m_rsp = '0; m_tmo = 1'b1;
        end
      end
    end else if (CMD_VALID) begin
      case (CMD_TYPE)
        2'b00: begin m_txq = '{8'hAA, CMD_ADDR, CMD_WDATA}; m_need = 0; end
        2'b01: begin m_txq = '{8'hBB, CMD_ADDR}; m_need = 1; end
        2'b10: begin m_txq = '{8'hCC, CMD_OP_A, CMD_OP_B, {4'h0, CMD_FUNC}}; m_need = 2; end
        default: begin m_txq = '{8'hDD, {4'h0, CMD_FUNC}}; m_need = 2; end
      endcase
    end
  end

  // Per-scenario observation log
  logic [7:0]  tx_log[$];
  int          tx_cyc[$];
  int          done_cnt, done_cyc, busy_hold;
  logic [15:0] done_rsp;
  logic        done_tmo;

  always @(negedge CLK) begin
    if (checking) begin
      check("cmd_ready", {15'b0, CMD_READY}, {15'b0, (m_txq.size() == 0) && !m_wait && !m_done});
      check("tx_valid", {15'b0, TX_VALID}, {15'b0, m_txq.size() != 0});
      if (m_txq.size() != 0) check("tx_data", {8'h0, TX_DATA}, {8'h0, m_txq[0]});
      if (!RST) check("tx_data_rst", {8'h0, TX_DATA}, 16'h0000);
      check("cmd_done", {15'b0, CMD_DONE}, {15'b0, m_done});
      check("rsp_data", RSP_DATA, m_rsp);
      check("rsp_timeout", {15'b0, RSP_TIMEOUT}, {15'b0, m_tmo});
    end
    if (TX_VALID === 1'b1 && TX_BUSY === 1'b0) begin tx_log.push_back(TX_DATA); tx_cyc.push_back(cyc_n); end
    if (TX_VALID === 1'b1 && TX_BUSY === 1'b1) busy_hold++;
    if (CMD_DONE === 1'b1) begin done_cnt++; done_cyc = cyc_n; done_rsp = RSP_DATA; done_tmo = RSP_TIMEOUT; end
  end

  task automatic cyc();
    @(posedge CLK); #1;
  endtask

  task automatic clear_log();
    tx_log.delete(); tx_cyc.delete(); done_cnt = 0; busy_hold = 0;
  endtask

  task automatic issue(input logic [1:0] t, input logic [7:0] a, input logic [7:0] w,
                       input logic [7:0] oa, input logic [7:0] ob, input logic [3:0] f);
    CMD_VALID = 1'b1; CMD_TYPE = t; CMD_ADDR = a; CMD_WDATA = w;
    CMD_OP_A = oa; CMD_OP_B = ob; CMD_FUNC = f;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin cyc(); n++; end
    check("done_within_budget", {15'b0, done_cnt != 0}, 16'h0001);
  endtask

  task automatic wait_tx(input int cnt, input int budget);
    int n = 0;
    while (tx_log.size() < cnt && n < budget) begin cyc(); n++; end
    check("tx_within_budget", {15'b0, tx_log.size() >= cnt}, 16'h0001);
  endtask

  task automatic check_bytes(input string name, input logic [7:0] exp[$]);
    check({name, "_count"}, 16'(tx_log.size()), 16'(exp.size()));
    for (int i = 0; i < exp.size() && i < tx_log.size(); i++)
      check(name, {8'h0, tx_log[i]}, {8'h0, exp[i]});
  endtask

  int rx_cyc;

  initial begin
    RST = 1'b0; CMD_VALID = 1'b0; CMD_TYPE = '0; CMD_ADDR = '0; CMD_WDATA = '0;
    CMD_OP_A = '0; CMD_OP_B = '0; CMD_FUNC = '0; TX_BUSY = 1'b0;
    RX_DATA = '0; RX_DATA_VALID = 1'b0;
    clear_log();
    cyc();
    checking = 1;
    repeat (2) cyc();
    check("rst_tx_valid", {15'b0, TX_VALID}, 16'h0000);
    check("rst_tx_data", {8'h0, TX_DATA}, 16'h0000);
    check("rst_rsp_data", RSP_DATA, 16'h0000);
    check("rst_cmd_done", {15'b0, CMD_DONE}, 16'h0000);
    check("rst_rsp_timeout", {15'b0, RSP_TIMEOUT}, 16'h0000);
    RST = 1'b1;
    cyc();
    check("ready_after_rst", {15'b0, CMD_READY}, 16'h0001);

    // Write: AA,05,3C back to back, done the next cycle
    clear_log();
    issue(2'b00, 8'h05, 8'h3C, 8'h00, 8'h00, 4'h0);
    cyc(); CMD_VALID = 1'b0;
    wait_done(20);
    check_bytes("wr_byte", '{8'hAA, 8'h05, 8'h3C});
    if (tx_cyc.size() == 3) begin
      check("wr_consecutive", 16'(tx_cyc[2] - tx_cyc[0]), 16'd2);
      check("wr_done_lat", 16'(done_cyc - tx_cyc[2]), 16'd1);
    end
    check("wr_rsp", done_rsp, 16'h0000);
    check("wr_tmo", {15'b0, done_tmo}, 16'h0000);

    // Read: BB,02 then response 7E
    cyc(); clear_log();
    issue(2'b01, 8'h02, 8'h00, 8'h00, 8'h00, 4'h0);
    cyc(); CMD_VALID = 1'b0;
    wait_tx(2, 20);
    repeat (3) cyc();
    RX_DATA = 8'h7E; RX_DATA_VALID = 1'b1; rx_cyc = cyc_n;
    cyc(); RX_DATA_VALID = 1'b0;
    wait_done(20);
    check_bytes("rd_byte", '{8'hBB, 8'h02});
    check("rd_rsp", done_rsp, 16'h007E);
    check("rd_done_lat", 16'(done_cyc - rx_cyc), 16'd1);

    // ALU under backpressure: 5 busy cycles per byte, stray RX while sending,
    // TX_BUSY and a new CMD_VALID with a different type during the wait
    cyc(); clear_log();
    issue(2'b10, 8'h00, 8'h00, 8'h0A, 8'h14, 4'h1);
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 5; i++) begin
        cyc(); CMD_VALID = 1'b0; TX_BUSY = 1'b1;
        RX_DATA = 8'hEE; RX_DATA_VALID = (b == 0 && i == 2);
      end
      cyc(); TX_BUSY = 1'b0;
    end
    cyc();
    TX_BUSY = 1'b1; issue(2'b00, 8'h77, 8'h77, 8'h77, 8'h77, 4'h7);
    RX_DATA = 8'h1E; RX_DATA_VALID = 1'b1;
    cyc(); RX_DATA_VALID = 1'b0;
    cyc(); RX_DATA = 8'h00; RX_DATA_VALID = 1'b1; CMD_VALID = 1'b0;
    cyc(); RX_DATA_VALID = 1'b0; TX_BUSY = 1'b0;
    wait_done(20);
    check_bytes("alu_byte", '{8'hCC, 8'h0A, 8'h14, 8'h01});
    check("alu_busy_hold", 16'(busy_hold), 16'd20);
    check("alu_rsp", done_rsp, 16'h001E);
    check("alu_tmo", {15'b0, done_tmo}, 16'h0000);

    // Timeout: one byte then silence
    cyc(); clear_log();
    issue(2'b11, 8'h00, 8'h00, 8'h00, 8'h00, 4'h3);
    cyc(); CMD_VALID = 1'b0;
    wait_tx(2, 20);
    repeat (2) cyc();
    RX_DATA = 8'h55; RX_DATA_VALID = 1'b1; rx_cyc = cyc_n;
    cyc(); RX_DATA_VALID = 1'b0;
    wait_done(40);
    check_bytes("tmo_byte", '{8'hDD, 8'h03});
    check("tmo_flag", {15'b0, done_tmo}, 16'h0001);
    check("tmo_rsp", done_rsp, 16'h0000);
    check("tmo_lat", 16'(done_cyc - rx_cyc), 16'd17);

    // Stray RX in IDLE changes nothing
    cyc(); clear_log();
    RX_DATA = 8'h99; RX_DATA_VALID = 1'b1;
    cyc(); RX_DATA_VALID = 1'b0;
    repeat (3) cyc();
    check("stray_no_done", 16'(done_cnt), 16'd0);
    check("stray_tmo_hold", {15'b0, RSP_TIMEOUT}, 16'h0001);
    check("stray_rsp_hold", RSP_DATA, 16'h0000);
    check("stray_ready", {15'b0, CMD_READY}, 16'h0001);

    // Reset during the second byte of an ALU frame
    clear_log();
    issue(2'b10, 8'h00, 8'h00, 8'h11, 8'h22, 4'h4);
    cyc(); CMD_VALID = 1'b0;
    cyc(); TX_BUSY = 1'b1;
    check("mid_tx_valid", {15'b0, TX_VALID}, 16'h0001);
    check("mid_tx_data", {8'h0, TX_DATA}, 16'h0011);
    #2 RST = 1'b0;
    #1 check("rst_async_tx_valid", {15'b0, TX_VALID}, 16'h0000);
    repeat (2) cyc();
    TX_BUSY = 1'b0; RST = 1'b1;
    cyc();
    check("ready_after_abort", {15'b0, CMD_READY}, 16'h0001);
    repeat (5) cyc();
    check("abort_no_done", 16'(done_cnt), 16'd0);
    check("abort_rsp_tmo", {15'b0, RSP_TIMEOUT}, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/cmd_frame_master.md
CMD_FRAME_MASTER -- requirements
Module: cmd_frame_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 4096: maximum idle cycles allowed before, or between, response bytes.
REQ-002 SHALL have port CLK  input  1  clock; all state changes on the rising edge.
REQ-003 SHALL have port RST  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port CMD_VALID  input  1  host command request.
REQ-005 SHALL have port CMD_READY  output  1  block can accept a command.
REQ-006 SHALL have port CMD_TYPE  input  2  command type: 00 = reg write (0xAA), 01 = reg read (0xBB), 10 = ALU with operands (0xCC), 11 = ALU without operands (0xDD).
REQ-007 SHALL have port CMD_ADDR  input  8  register-file address (types 00 and 01).
REQ-008 SHALL have port CMD_WDATA  input  8  write data (type 00).
REQ-009 SHALL have ports CMD_OP_A and CMD_OP_B  input  8 each  ALU operands (type 10).
REQ-010 SHALL have port CMD_FUNC  input  4  ALU function (types 10 and 11).
REQ-011 SHALL have port TX_DATA  output  8  byte offered to the UART transmitter.
REQ-012 SHALL have port TX_VALID  output  1  TX_DATA is valid.
REQ-013 SHALL have port TX_BUSY  input  1  UART transmitter cannot take a byte.
REQ-014 SHALL have ports RX_DATA  input  8  and RX_DATA_VALID  input  1  received response byte; RX_DATA_VALID is a one-cycle pulse per byte.
REQ-015 SHALL have port RSP_DATA  output  16  assembled response.
REQ-016 SHALL have ports CMD_DONE  output  1  and RSP_TIMEOUT  output  1  completion pulse and timeout flag.

Function
REQ-017 SHALL use the FSM states IDLE, SEND, WAIT_RSP and DONE.
REQ-018 SHALL assert CMD_READY combinationally only in IDLE; a command is accepted when CMD_VALID and CMD_READY are both 1, at which point all CMD_* fields are latched and the FSM moves to SEND.
REQ-019 SHALL send these frames in order, one byte per accept:
  - 00: AA, ADDR, WDATA
  - 01: BB, ADDR
  - 10: CC, OP_A, OP_B, {4'h0,FUNC}
  - 11: DD, {4'h0,FUNC}
REQ-020 SHALL drive TX_VALID and TX_DATA from registers.
REQ-021 SHALL treat a byte as accepted on a cycle where TX_VALID=1 and TX_BUSY=0.
REQ-022 SHALL hold TX_DATA and TX_VALID stable until the byte is accepted; on acceptance the byte index increments and the next byte is presented on the following cycle, which gives one-cycle TX_VALID continuity with no bubble.
REQ-023 SHALL set the expected response length to 0 bytes for type 00, 1 byte for type 01, and 2 bytes for types 10 and 11.
REQ-024 SHALL, once the last frame byte is accepted, deassert TX_VALID and go to DONE if the expected length is 0, otherwise to WAIT_RSP.
REQ-025 SHALL, in WAIT_RSP, capture RX_DATA on each RX_DATA_VALID: for type 01, RSP_DATA={8'h00,byte0}; for types 10 and 11, byte0 is the LSB and byte1 the MSB. After the final byte the FSM goes to DONE.
REQ-026 SHALL ignore RX_DATA_VALID pulses in IDLE, SEND and DONE; bytes are dropped and no state changes.
REQ-027 SHALL run a timeout counter in WAIT_RSP that clears on entry and on every received byte; if it reaches TIMEOUT_CYCLES-1 without a byte, the FSM goes to DONE with RSP_TIMEOUT=1 and RSP_DATA=16'h0000.
REQ-028 SHALL assert CMD_DONE for exactly one cycle in DONE, with RSP_DATA and RSP_TIMEOUT valid in that cycle, then return to IDLE; RSP_DATA and RSP_TIMEOUT hold until the next DONE.
REQ-029 SHALL keep the minimum command-to-command spacing at one IDLE cycle after DONE, so CMD_READY is 0 during DONE.
REQ-030 SHALL NOT let TX_BUSY affect WAIT_RSP, and SHALL NOT let CMD_VALID affect any state other than IDLE.

Reset
REQ-031 SHALL, while RST=0, force: state IDLE; TX_VALID=0; TX_DATA=8'h00; RSP_DATA=16'h0000; CMD_DONE=0; RSP_TIMEOUT=0; counters cleared.
REQ-032 SHALL, on reset asserted mid-frame or mid-wait, abandon the in-flight command with no CMD_DONE, and come out of reset ready (CMD_READY=1) on the first clock after RST rises.

Verification
REQ-033 SHALL cover a write: type 00, ADDR=05, WDATA=3C, TX_BUSY=0 -> TX bytes AA,05,3C on 3 consecutive cycles, then CMD_DONE one cycle later with RSP_DATA=0000 and RSP_TIMEOUT=0.
REQ-034 SHALL cover a read: type 01, ADDR=02 -> TX BB,02; RX byte 7E -> CMD_DONE with RSP_DATA=007E.
REQ-035 SHALL cover an ALU command under backpressure: type 10, OP_A=0A, OP_B=14, FUNC=1, TX_BUSY held high 5 cycles per byte -> TX CC,0A,14,01 with each byte stable while busy; RX 1E then 00 -> RSP_DATA=001E.
REQ-036 SHALL cover a timeout: TIMEOUT_CYCLES=16, type 11, FUNC=3, one RX byte then silence -> CMD_DONE with RSP_TIMEOUT=1 and RSP_DATA=0000, 16 cycles after the last byte.
REQ-037 SHALL cover stray input and reset: an RX_DATA_VALID pulse in IDLE leaves state and outputs unchanged; RST low during the second TX byte of type 10 -> TX_VALID=0 immediately, no CMD_DONE, and CMD_READY=1 after release.
